// File: rtl/io_pkg.sv
// Shared definitions for the console I/O paths (decimal input and display).
// Holds the controller state encoding, digit/word geometry and a BCD digit check.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_KEY = 2'd1,
        CONVERT  = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int NUM_DIGITS = 3;
    localparam int BIN_BITS   = 10;
    localparam int DIGIT_W    = 4;
    localparam int BCD_MAX    = 9;
    localparam int DATA_W     = 32;

    // A nibble is a legal decimal digit when it does not exceed nine.
    function automatic logic bcd_digit_ok(input logic [DIGIT_W-1:0] digit);
        return (digit <= DIGIT_W'(BCD_MAX));
    endfunction

endpackage

// File: rtl/decimal_input_key_conditioner.sv
// Enter-key conditioning: two-flop synchroniser, optional debounce and a
// falling-edge detector that emits one pulse per press.
// Debounce is built only when DECIMAL_INPUT_DEBOUNCE_EN is defined.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    logic sync1_r;
    logic sync2_r;
    logic level_s;
    logic prev_r;

    // Bring the raw button into the clock domain; released level is 1.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
        end
    end

`ifdef DECIMAL_INPUT_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CNT_W-1:0] deb_cnt_r;
    logic             deb_level_r;

    // Accept a new level only after it has been stable for DEBOUNCE_CYCLES samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            deb_cnt_r   <= {CNT_W{1'b0}};
            deb_level_r <= 1'b1;
        end else if (sync2_r != deb_level_r) begin
            if (deb_cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_level_r <= sync2_r;
                deb_cnt_r   <= {CNT_W{1'b0}};
            end else begin
                deb_cnt_r <= deb_cnt_r + CNT_W'(1);
            end
        end else begin
            deb_cnt_r <= {CNT_W{1'b0}};
        end
    end

    assign level_s = deb_level_r;
`else
    assign level_s = sync2_r;
`endif

    // Remember the previous conditioned level for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= level_s;
        end
    end

    // One-cycle pulse on the high-to-low transition; holding the key gives one pulse.
    assign press = prev_r & ~level_s;

endmodule

// File: rtl/decimal_input.sv
// Console decimal input: waits for an IN request, captures three BCD digits and
// a sign on an Enter press, converts BCD to binary by reverse double-dabble and
// returns a sign-extended word over a level request/valid handshake.
// Optional key debounce: define DECIMAL_INPUT_DEBOUNCE_EN.
module decimal_input #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int NUM_DIGITS      = io_pkg::NUM_DIGITS,
    parameter int BIN_BITS        = io_pkg::BIN_BITS
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    inRequest,
    input  logic [4*NUM_DIGITS-1:0] swBcd,
    input  logic                    swSign,
    input  logic                    keyEnter_n,
    output logic [31:0]             inData,
    output logic                    inValid,
    output logic                    bcdError,
    output logic                    waiting
);

    import io_pkg::*;

    localparam int BCD_W = DIGIT_W * NUM_DIGITS;
    localparam int SR_W  = BCD_W + BIN_BITS;
    localparam int CNT_W = $clog2(BIN_BITS + 1);

    state_t              state_r;
    state_t              next_state_s;
    logic [SR_W-1:0]     shift_r;
    logic [SR_W-1:0]     dabble_s;
    logic [CNT_W-1:0]    iter_r;
    logic                sign_r;
    logic                press_s;
    logic                digits_ok_s;
    logic                capture_s;
    logic [BIN_BITS-1:0] mag_s;
    logic [DATA_W-1:0]   mag_ext_s;
    logic [DATA_W-1:0]   result_s;
    logic [DATA_W-1:0]   in_data_r;
    logic                in_valid_r;
    logic                bcd_error_r;
    logic                waiting_r;

    key_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clock (clock),
        .reset (reset),
        .key_n (keyEnter_n),
        .press (press_s)
    );

    // Flag whether every switch digit is a legal decimal digit.
    always_comb begin
        digits_ok_s = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (!bcd_digit_ok(swBcd[d*DIGIT_W +: DIGIT_W])) begin
                digits_ok_s = 1'b0;
            end else begin
                digits_ok_s = digits_ok_s;
            end
        end
    end

    assign capture_s = (state_r == WAIT_KEY) && inRequest && press_s;

    // One reverse double-dabble step: shift right, then correct each digit >= 8.
    always_comb begin
        dabble_s = shift_r >> 1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (dabble_s[BIN_BITS + d*DIGIT_W +: DIGIT_W] >= DIGIT_W'(8)) begin
                dabble_s[BIN_BITS + d*DIGIT_W +: DIGIT_W] =
                    dabble_s[BIN_BITS + d*DIGIT_W +: DIGIT_W] - DIGIT_W'(3);
            end else begin
                dabble_s[BIN_BITS + d*DIGIT_W +: DIGIT_W] =
                    dabble_s[BIN_BITS + d*DIGIT_W +: DIGIT_W];
            end
        end
    end

    assign mag_s     = shift_r[BIN_BITS-1:0];
    assign mag_ext_s = {{(DATA_W-BIN_BITS){1'b0}}, mag_s};

    // Apply the sign; a negative zero is reported as plain zero.
    always_comb begin
        if (sign_r && (mag_s != {BIN_BITS{1'b0}})) begin
            result_s = -mag_ext_s;
        end else begin
            result_s = mag_ext_s;
        end
    end

    // Controller state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a dropped request always wins over a press.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (inRequest) next_state_s = WAIT_KEY;
                else           next_state_s = IDLE;
            end
            WAIT_KEY: begin
                if (!inRequest)                   next_state_s = IDLE;
                else if (press_s && digits_ok_s)  next_state_s = CONVERT;
                else                              next_state_s = WAIT_KEY;
            end
            CONVERT: begin
                if (!inRequest)                           next_state_s = IDLE;
                else if (iter_r == CNT_W'(BIN_BITS))      next_state_s = DONE;
                else                                      next_state_s = CONVERT;
            end
            DONE: begin
                if (!inRequest) next_state_s = IDLE;
                else            next_state_s = DONE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Capture, conversion datapath and registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_r     <= {SR_W{1'b0}};
            iter_r      <= {CNT_W{1'b0}};
            sign_r      <= 1'b0;
            in_data_r   <= {DATA_W{1'b0}};
            in_valid_r  <= 1'b0;
            bcd_error_r <= 1'b0;
            waiting_r   <= 1'b0;
        end else begin
            waiting_r  <= (next_state_s == WAIT_KEY);
            in_valid_r <= (next_state_s == DONE);
            if (capture_s) begin
                bcd_error_r <= ~digits_ok_s;
                if (digits_ok_s) begin
                    shift_r <= {swBcd, {BIN_BITS{1'b0}}};
                    iter_r  <= {CNT_W{1'b0}};
                    sign_r  <= swSign;
                end
            end else if ((state_r == CONVERT) && inRequest) begin
                if (iter_r != CNT_W'(BIN_BITS)) begin
                    shift_r <= dabble_s;
                    iter_r  <= iter_r + CNT_W'(1);
                end else begin
                    in_data_r <= result_s;
                end
            end
        end
    end

    assign inData   = in_data_r;
    assign inValid  = in_valid_r;
    assign bcdError = bcd_error_r;
    assign waiting  = waiting_r;

endmodule

// File: tb/tb_decimal_input.sv
// Self-checking bench for decimal_input: table vectors, hand-written handshake
// corner cases and randomised entries checked against a decimal-arithmetic model.
module tb_decimal_input;

`ifdef DECIMAL_INPUT_DEBOUNCE_EN
    localparam int DEB = 4;
`else
    localparam int DEB = 0;
`endif
    localparam int HOLD = DEB + 3;
    localparam int LAT  = 14 + DEB;

    logic        clock;
    logic        reset;
    logic        inRequest;
    logic [11:0] swBcd;
    logic        swSign;
    logic        keyEnter_n;
    logic [31:0] inData;
    logic        inValid;
    logic        bcdError;
    logic        waiting;

    int          tests;
    int          fails;
    logic [31:0] last_good;

    typedef struct {
        logic [11:0] bcd;
        logic        sign;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    decimal_input #(.DEBOUNCE_CYCLES(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .inRequest  (inRequest),
        .swBcd      (swBcd),
        .swSign     (swSign),
        .keyEnter_n (keyEnter_n),
        .inData     (inData),
        .inValid    (inValid),
        .bcdError   (bcdError),
        .waiting    (waiting)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Decimal model: value from digit weights, negated when the sign is set.
    function automatic void model(input logic [11:0] bcd, input logic sgn,
                                  output logic err, output logic [31:0] val);
        int h, t, o, m;
        h = int'(bcd[11:8]);
        t = int'(bcd[7:4]);
        o = int'(bcd[3:0]);
        err = (h > 9) || (t > 9) || (o > 9);
        m = h * 100 + t * 10 + o;
        if (sgn) m = -m;
        val = 32'(m);
    endfunction

    // One full entry from WAIT_KEY: press, wait for result, complete handshake.
    task automatic entry(input string name, input logic [11:0] bcd, input logic sgn,
                         input logic exp_err, input logic [31:0] exp_data);
        int lat;
        bit seen;
        swBcd = bcd;
        swSign = sgn;
        keyEnter_n = 1'b0;
        lat = 0;
        seen = 1'b0;
        for (int c = 1; c <= LAT + 20 && !seen; c++) begin
            tick();
            if (c == HOLD) keyEnter_n = 1'b1;
            if (inValid) begin
                seen = 1'b1;
                lat = c;
            end
        end
        keyEnter_n = 1'b1;
        if (exp_err) begin
            check({name, " no_valid"}, 32'(seen), 32'd0);
            check({name, " bcdError"}, 32'(bcdError), 32'd1);
            check({name, " waiting"}, 32'(waiting), 32'd1);
            check({name, " data_held"}, inData, last_good);
        end else begin
            check({name, " latency"}, 32'(lat), 32'(LAT));
            check({name, " data"}, inData, exp_data);
            check({name, " bcdError"}, 32'(bcdError), 32'd0);
            repeat (3) tick();
            check({name, " valid_hold"}, 32'(inValid), 32'd1);
            inRequest = 1'b0;
            tick();
            check({name, " valid_drop"}, 32'(inValid), 32'd0);
            check({name, " data_keep"}, inData, exp_data);
            last_good = exp_data;
            inRequest = 1'b1;
            repeat (HOLD) tick();
            check({name, " rewait"}, 32'(waiting), 32'd1);
        end
    endtask

    initial begin
        bit          any_valid;
        logic        m_err;
        logic [31:0] m_val;
        logic [11:0] r_bcd;
        logic        r_sign;

        tests = 0;
        fails = 0;
        last_good = 32'd0;
        vecs[0] = '{12'h123, 1'b0, 1'b0, 32'h0000007B};
        vecs[1] = '{12'h999, 1'b1, 1'b0, 32'hFFFFFC19};
        vecs[2] = '{12'h000, 1'b1, 1'b0, 32'h00000000};
        vecs[3] = '{12'h1A5, 1'b0, 1'b1, 32'h00000000};
        vecs[4] = '{12'h105, 1'b0, 1'b0, 32'h00000069};
        vecs[5] = '{12'h500, 1'b1, 1'b0, 32'hFFFFFE0C};

        reset = 1'b1;
        inRequest = 1'b0;
        keyEnter_n = 1'b1;
        swBcd = 12'h000;
        swSign = 1'b0;
        repeat (3) tick();
        check("rst inData", inData, 32'd0);
        check("rst inValid", 32'(inValid), 32'd0);
        check("rst bcdError", 32'(bcdError), 32'd0);
        check("rst waiting", 32'(waiting), 32'd0);
        reset = 1'b0;
        tick();
        check("idle waiting", 32'(waiting), 32'd0);
        inRequest = 1'b1;
        tick();
        check("req waiting", 32'(waiting), 32'd1);

        for (int i = 0; i < 6; i++) begin
            entry($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].sign,
                  vecs[i].exp_err, vecs[i].exp_data);
        end

        // Abort on the 5th conversion cycle.
        swBcd = 12'h321;
        swSign = 1'b0;
        keyEnter_n = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == HOLD) keyEnter_n = 1'b1;
        end
        inRequest = 1'b0;
        tick();
        keyEnter_n = 1'b1;
        check("abort waiting", 32'(waiting), 32'd0);
        any_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (inValid) any_valid = 1'b1;
        end
        check("abort no_valid", 32'(any_valid), 32'd0);
        check("abort data_keep", inData, last_good);

        // Press while idle is ignored.
        keyEnter_n = 1'b0;
        repeat (HOLD) tick();
        keyEnter_n = 1'b1;
        repeat (HOLD) tick();
        inRequest = 1'b1;
        any_valid = 1'b0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (inValid) any_valid = 1'b1;
        end
        check("idlepress waiting", 32'(waiting), 32'd1);
        check("idlepress no_valid", 32'(any_valid), 32'd0);
        entry("after_idle", 12'h246, 1'b1, 1'b0, 32'hFFFFFF0A);

        // Key held across one request into the next.
        swBcd = 12'h042;
        swSign = 1'b0;
        keyEnter_n = 1'b0;
        any_valid = 1'b0;
        for (int c = 1; c <= LAT + 20 && !any_valid; c++) begin
            tick();
            if (inValid) any_valid = 1'b1;
        end
        check("held first_valid", 32'(any_valid), 32'd1);
        check("held first_data", inData, 32'h0000002A);
        last_good = 32'h0000002A;
        inRequest = 1'b0;
        tick();
        inRequest = 1'b1;
        any_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (inValid) any_valid = 1'b1;
        end
        check("held no_repeat", 32'(any_valid), 32'd0);
        check("held waiting", 32'(waiting), 32'd1);
        keyEnter_n = 1'b1;
        repeat (HOLD) tick();
        entry("held_repress", 12'h007, 1'b0, 1'b0, 32'h00000007);

        // Randomised entries against the decimal model.
        for (int i = 0; i < 16; i++) begin
            r_bcd = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 10)), 4'($urandom_range(0, 10))};
            r_sign = 1'($urandom_range(0, 1));
            model(r_bcd, r_sign, m_err, m_val);
            entry($sformatf("rnd%0d_%03h", i, r_bcd), r_bcd, r_sign, m_err, m_val);
        end

        // Reset in the middle of a conversion.
        swBcd = 12'h555;
        swSign = 1'b1;
        keyEnter_n = 1'b0;
        repeat (6) tick();
        reset = 1'b1;
        tick();
        check("midrst inData", inData, 32'd0);
        check("midrst inValid", 32'(inValid), 32'd0);
        check("midrst bcdError", 32'(bcdError), 32'd0);
        check("midrst waiting", 32'(waiting), 32'd0);
        keyEnter_n = 1'b1;
        reset = 1'b0;
        last_good = 32'd0;
        repeat (HOLD) tick();
        check("midrst rewait", 32'(waiting), 32'd1);
        entry("after_rst", 12'h321, 1'b0, 1'b0, 32'h00000141);

`ifdef DECIMAL_INPUT_DEBOUNCE_EN
        // Short glitch must not register as a press.
        keyEnter_n = 1'b0;
        repeat (3) tick();
        keyEnter_n = 1'b1;
        any_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (inValid) any_valid = 1'b1;
        end
        check("glitch no_valid", 32'(any_valid), 32'd0);
        check("glitch waiting", 32'(waiting), 32'd1);
        entry("deb_accept", 12'h088, 1'b1, 1'b0, 32'hFFFFFFA8);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
